// File: rtl/imem_loader.sv
// Boot loader: parses a byte stream (count header, little-endian payload, XOR checksum) into instruction RAM.
// Latency: a word's write strobe is registered on the edge accepting its fourth byte; done/error on the checksum edge.
// Backpressure: s_ready is high in HEADER/LOAD/CHECK and low in terminal states and during reset; idle cycles are transparent.
module imem_loader #(
    parameter int MAX_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [5:0]  word_count
);

    typedef enum logic [2:0] {
        HEADER,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Header values are compared at 9 bits so any byte value is range-checked safely.
    localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

    state_t      state;
    logic [7:0]  n_words;
    logic [1:0]  byte_idx;
    logic [7:0]  xor_acc;
    logic [23:0] word_buf;
    logic        xfer;

    // Ready only while parsing; forced low during reset so no byte is consumed in that cycle.
    assign s_ready = !reset && ((state == HEADER) || (state == LOAD) || (state == CHECK));
    assign xfer    = s_valid && s_ready;

    // Frame parser: state, byte assembly, running checksum and registered RAM write / status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HEADER;
            n_words    <= 8'd0;
            byte_idx   <= 2'd0;
            xor_acc    <= 8'd0;
            word_buf   <= 24'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= 32'd0;
            word_count <= 6'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_reset  <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            if (xfer) begin
                case (state)
                    HEADER: begin
                        if ((s_data != 8'd0) && ({1'b0, s_data} <= MAX_N)) begin
                            n_words <= s_data;
                            state   <= LOAD;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                    LOAD: begin
                        xor_acc  <= xor_acc ^ s_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= s_data;
                            2'd1: word_buf[15:8]  <= s_data;
                            2'd2: word_buf[23:16] <= s_data;
                            default: begin
                                // Fourth byte completes the word: first byte lands in bits [7:0].
                                wr_en      <= 1'b1;
                                wr_addr    <= word_count[4:0];
                                wr_data    <= {s_data, word_buf};
                                word_count <= word_count + 6'd1;
                                if (({2'b00, word_count} + 8'd1) == n_words) begin
                                    state <= CHECK;
                                end
                            end
                        endcase
                    end
                    CHECK: begin
                        if (s_data == xor_acc) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE and ERROR hold until reset; s_ready is low so this is unreachable.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames with gaps.
// Expected RAM writes and status come from a frame-level model (bytes -> words, XOR of payload).
// Writes are logged every cycle on the falling edge so stretched or extra strobes show up as extra entries.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [5:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [36:0] wr_log[$];

    imem_loader #(.MAX_WORDS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Record every cycle in which the write strobe is high.
    always @(negedge clk) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Offer one byte after a random idle gap and hold it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: s_ready=%0b required 1 for byte %02h", s_ready, b);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic do_reset(input bit check);
        reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        if (check) begin
            checks++;
            if ({s_ready, wr_en, wr_addr, wr_data, word_count, done, error, cpu_reset} !==
                {1'b0, 1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_values: rdy=%0b wr_en=%0b addr=%0d data=%08h wc=%0d done=%0b err=%0b cpu_rst=%0b required 0,0,0,0,0,0,0,1",
                         s_ready, wr_en, wr_addr, wr_data, word_count, done, error, cpu_reset);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        if (check) begin
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset: s_ready=%0b required 1", s_ready);
            end
        end
    endtask

    // Send a frame with a valid header and check writes and final status against the model.
    task automatic run_frame(input string name, input logic [7:0] pay[$], input logic [7:0] cks,
                             input int max_gap);
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        logic [4:0]  a;
        bit          good;
        int          log_sz;
        n = pay.size() / 4;
        x = 8'd0;
        foreach (pay[i]) x = x ^ pay[i];
        good = (cks == x);
        wr_log.delete();
        send_byte(8'(n), max_gap);
        foreach (pay[i]) send_byte(pay[i], max_gap);
        send_byte(cks, max_gap);
        repeat (2) @(negedge clk);

        checks++;
        if (wr_log.size() !== n) begin
            errors++;
            $display("FAIL %s write_count: got %0d pulses required %0d", name, wr_log.size(), n);
        end
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            w = 32'(pay[4*i]) + (32'(pay[4*i+1]) << 8) + (32'(pay[4*i+2]) << 16) + (32'(pay[4*i+3]) << 24);
            a = 5'(i);
            checks++;
            if (wr_log[i] !== {a, w}) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr %0d data %08h required addr %0d data %08h",
                         name, i, wr_log[i][36:32], wr_log[i][31:0], a, w);
            end
        end
        checks++;
        if ({done, error, cpu_reset, s_ready, word_count} !== {good, !good, !good, 1'b0, 6'(n)}) begin
            errors++;
            $display("FAIL %s status: done=%0b err=%0b cpu_rst=%0b rdy=%0b wc=%0d required %0b,%0b,%0b,0,%0d",
                     name, done, error, cpu_reset, s_ready, word_count, good, !good, !good, n);
        end

        // Terminal state: further offered bytes must change nothing.
        log_sz  = wr_log.size();
        s_valid = 1'b1;
        repeat (6) begin
            s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if ({wr_log.size() == log_sz, done, error, word_count} !== {1'b1, good, !good, 6'(n)}) begin
            errors++;
            $display("FAIL %s terminal_hold: writes %0d->%0d done=%0b err=%0b wc=%0d required no writes, %0b,%0b,%0d",
                     name, log_sz, wr_log.size(), done, error, word_count, good, !good, n);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
    endtask

    task automatic test_basic_frame();
        logic [7:0] p[$] = '{8'h93, 8'h00, 8'h50, 8'h00};
        do_reset(1'b0);
        run_frame("basic", p, 8'hC3, 0);
    endtask

    task automatic test_bad_checksum();
        logic [7:0] p[$] = '{8'h93, 8'h00, 8'h50, 8'h00};
        do_reset(1'b0);
        run_frame("bad_cks", p, 8'hC2, 0);
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs[2] = '{8'h00, 8'h21};
        foreach (hdrs[k]) begin
            do_reset(1'b0);
            wr_log.delete();
            send_byte(hdrs[k], 0);
            checks++;
            if ({error, done, cpu_reset, s_ready} !== 4'b1010) begin
                errors++;
                $display("FAIL bad_header_%02h: err=%0b done=%0b cpu_rst=%0b rdy=%0b required 1,0,1,0",
                         hdrs[k], error, done, cpu_reset, s_ready);
            end
            s_valid = 1'b1;
            repeat (8) begin
                s_data = 8'($urandom);
                @(negedge clk);
            end
            s_valid = 1'b0;
            checks++;
            if (wr_log.size() !== 0 || word_count !== 6'd0 || error !== 1'b1) begin
                errors++;
                $display("FAIL bad_header_%02h_hold: writes=%0d wc=%0d err=%0b required 0,0,1",
                         hdrs[k], wr_log.size(), word_count, error);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] p[$] = '{8'h13, 8'h00, 8'h00, 8'h00};
        do_reset(1'b0);
        wr_log.delete();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        do_reset(1'b1);
        checks++;
        if (wr_log.size() !== 0) begin
            errors++;
            $display("FAIL mid_reset_stale: got %0d writes required 0", wr_log.size());
        end
        run_frame("after_mid_reset", p, 8'h13, 0);
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] p[$];
            logic [7:0] x;
            int         n;
            string      nm;
            n = (k == 0) ? 32 : int'($urandom_range(32, 1));
            x = 8'd0;
            p.delete();
            for (int i = 0; i < 4 * n; i++) begin
                p.push_back(8'($urandom));
                x = x ^ p[i];
            end
            if (k % 3 == 2) x = x ^ 8'($urandom_range(255, 1));
            nm = $sformatf("rand%0d_n%0d", k, n);
            do_reset(1'b0);
            run_frame(nm, p, x, (k == 0) ? 3 : k % 4);
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_frame();
        test_bad_checksum();
        test_bad_header();
        test_reset_mid_frame();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: MAX_WORDS, 32, instruction RAM depth in 32-bit words; header values above this are rejected.
REQ-002 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: s_valid  input  1  byte-stream source has a byte on s_data.
REQ-005 Port: s_ready  output  1  loader accepts a byte; a transfer occurs on an edge where s_valid && s_ready.
REQ-006 Port: s_data  input  8  stream byte.
REQ-007 Port: wr_en  output  1  one-cycle write strobe to instruction RAM.
REQ-008 Port: wr_addr  output  5  word index written, 0..MAX_WORDS-1.
REQ-009 Port: wr_data  output  32  assembled instruction word.
REQ-010 Port: cpu_reset  output  1  holds CPU in reset until the image is loaded and verified.
REQ-011 Port: done  output  1  image loaded, checksum matched; sticky.
REQ-012 Port: error  output  1  bad header or checksum mismatch; sticky.
REQ-013 Port: word_count  output  6  number of words written so far.

Function
REQ-014 The frame format SHALL be: header byte N (word count), then 4*N payload bytes, then one checksum byte.
REQ-015 Payload bytes SHALL be little-endian: the first byte of each group of four is wr_data[7:0] and the fourth is wr_data[31:24].
REQ-016 The checksum SHALL be the bitwise XOR of all 4*N payload bytes; the header is excluded.
REQ-017 The state machine SHALL have the states HEADER, LOAD, CHECK, DONE and ERROR.
REQ-018 HEADER: on an accepted byte N with 1 <= N <= MAX_WORDS, go to LOAD and latch N; on N=0 or N>MAX_WORDS, go to ERROR.
REQ-019 LOAD: every accepted byte SHALL update a 2-bit byte index and the running XOR.
REQ-020 LOAD: on the edge that accepts the fourth byte of a word, wr_en, wr_addr (equal to word_count) and wr_data SHALL be registered, so that wr_en is high for exactly the next cycle, and word_count SHALL increment on the same edge.
REQ-021 LOAD: once the fourth byte of word N-1 is accepted, go to CHECK.
REQ-022 CHECK: on an accepted byte equal to the running XOR, go to DONE; otherwise go to ERROR.
REQ-023 s_ready SHALL be 1 in HEADER, LOAD and CHECK, and 0 in DONE and ERROR.
REQ-024 No state, counter or XOR change SHALL occur on a cycle without a transfer; gaps in s_valid are transparent.
REQ-025 wr_en SHALL be 0 in all cycles except those defined in REQ-020; wr_addr and wr_data SHALL hold their last values otherwise.
REQ-026 done SHALL be 1 exactly in DONE; error SHALL be 1 exactly in ERROR; both are registered and change on the transition edge.
REQ-027 cpu_reset SHALL equal !done, registered; it is never deasserted in ERROR.
REQ-028 DONE and ERROR SHALL be terminal until reset.
REQ-029 wr_addr SHALL never exceed N-1; word_count SHALL never exceed N.

Reset
REQ-030 While reset is asserted, the loader SHALL enter HEADER with: s_ready=0 during the reset cycle, wr_en=0, wr_addr=0, wr_data=0, word_count=0, done=0, error=0, cpu_reset=1, byte index 0 and XOR 0.
REQ-031 Reset asserted mid-frame (LOAD or CHECK) SHALL discard the partial word and the running XOR with no wr_en pulse; the next byte is treated as a header.
REQ-032 s_ready SHALL be 1 on the first cycle after reset is deasserted.

Verification
REQ-033 Bytes 01,93,00,50,00,C3 sent back-to-back: a single wr_en pulse with wr_addr=0 and wr_data=0x00500093; then done=1, cpu_reset=0, word_count=1, s_ready=0.
REQ-034 The same frame with checksum C2: wr_en pulses once, then error=1, done=0, cpu_reset=1, s_ready=0, and further bytes are ignored.
REQ-035 Header 00, and separately header 21 (33): error=1 on the cycle after the header, with no wr_en pulse ever.
REQ-036 A 32-word frame with random s_valid gaps: 32 wr_en pulses with wr_addr 0..31 in order and data matching, then done=1 with word_count=32.
REQ-037 Reset after header 02 and two payload bytes, then a full frame 01,13,00,00,00,13: no stale write; one write of 0x00000013 to address 0, then done=1.
